vec_dispatch_sched: RTL and testbench
=====================================

# vec_dispatch_sched

Dispatch scheduler in front of the vector unit's work consumer. It accepts 6-bit job codes from several requesters through valid/ready handshakes and arbitrates between them round-robin. Accepted jobs are buffered in a small FIFO, and each job is issued to the consumer as a one-cycle nonzero `select_o` pulse, only while the consumer reports not busy. It then tracks the consumer's busy acknowledge/complete sequence before issuing the next job. Job code 0 is reserved as "no work" on the consumer side.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `FIFO_DEPTH`, default 4: job buffer entries; power of two, ≥2.
- `ACK_TIMEOUT`, default 15: cycles allowed in WAIT_ACK before timeout (with macro only), 1..255.

Ports:
- `clk_i`  in  1  the single clock; all logic on its rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `req_valid_i`  in  NREQ  per-requester job valid.
- `req_job_i`  in  6*NREQ  job code of requester k in bits [6k+5:6k].
- `req_ready_o`  out  NREQ  one-hot grant; a transfer occurs on valid&ready.
- `busy_consumer_i`  in  1  consumer busy flag.
- `select_o`  out  6  job code to consumer; 0 = no work.
- `issue_src_o`  out  $clog2(NREQ)  requester index of the job in `select_o`; valid while `select_o`≠0.
- `fifo_count_o`  out  $clog2(FIFO_DEPTH)+1  current buffered jobs.
- `timeout_o`  out  1  one-cycle pulse on ACK timeout.

## Operation
- **Eligibility.** Requester k is eligible when `req_valid_i[k]`=1 and its job≠0. A zero job never receives ready.
- **Arbitration.** Combinational round-robin starting at pointer `rr`.
  - The lowest-index eligible requester at or after `rr` (with wrap) is granted, provided count<FIFO_DEPTH.
  - Exactly one grant per cycle, at most.
  - On a grant to k, `rr` becomes (k+1) mod NREQ; otherwise `rr` holds.
- **FIFO.** Each entry stores {src, job}.
  - Fullness is judged on the registered count. A full FIFO grants nothing, even if a pop happens in the same cycle.
  - A push and a pop in the same cycle leave count unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- **FSM states:** IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
  - IDLE: if count>0 and `busy_consumer_i`=0, pop the head into the issue register and go to ISSUE. Otherwise stay.
  - ISSUE: drive `select_o`=job and `issue_src_o`=src for exactly this one cycle, then go to WAIT_ACK.
  - WAIT_ACK: when `busy_consumer_i`=1, go to WAIT_DONE.
  - WAIT_DONE: when `busy_consumer_i`=0, go to IDLE.
- `select_o`=0 in every state except ISSUE.
- Busy already high in IDLE blocks the issue. Busy high during ISSUE still counts as the acknowledge on the next cycle.

## Timing
- **Reset values.**
  - FSM=IDLE, `rr`=0, FIFO empty.
  - `select_o`=0, `issue_src_o`=0, `fifo_count_o`=0, `timeout_o`=0.
  - `req_ready_o`=0 during the reset cycle.
- **Reset mid-operation.** Aborts any pending or issued job and flushes the FIFO. No timeout pulse is produced.
- **Latency.** A handshake in cycle t enters the FIFO at t+1. With an idle FSM and busy low, `select_o` is nonzero in cycle t+2.
- **Throughput.** Minimum 4 cycles per job with a one-cycle consumer busy pulse: ISSUE, WAIT_ACK, WAIT_DONE, IDLE.
- **Registered outputs.** `select_o`, `issue_src_o`, `fifo_count_o` and `timeout_o` are registered.
- **Combinational output.** `req_ready_o` is combinational from the inputs, `rr` and count.

## Configuration
- **`VEC_DISPATCH_TIMEOUT_EN` defined.**
  - An 8-bit counter clears on entry to WAIT_ACK and increments each cycle busy stays low.
  - On reaching ACK_TIMEOUT, `timeout_o` pulses for 1 cycle, the job is dropped and the FSM returns to IDLE.
  - Busy arriving in the same cycle as the timeout takes priority: go to WAIT_DONE, no pulse.
- **Not defined.**
  - No counter is built; WAIT_ACK waits indefinitely.
  - `timeout_o` is tied to 0.

## Test plan
- **Single job.** Reset, busy=0, requester 1 valid with job 6'h05 for one cycle.
  - Required: ready[1]=1 at t; `select_o`=5 and `issue_src_o`=1 at t+2 only.
  - Then busy=1 for 3 cycles and 0 afterwards. Required: FSM back in IDLE, `fifo_count_o`=0.
- **Round-robin.** All 4 requesters valid continuously with jobs 1,2,3,4; consumer acknowledges every job.
  - Required: grant order 0,1,2,3,0; issue order 1,2,3,4.
- **Full FIFO.** Consumer busy held at 1; 5 jobs offered.
  - Required: 4 accepted, `fifo_count_o`=4, ready stays 0 for the 5th.
  - Release busy. Required: FIFO drains in order, with the 5th accepted once count<4.
- **Zero job and busy blocking.**
  - Requester 0 with job 0: required never ready, no issue.
  - Valid job while busy=1 in IDLE: required `select_o` stays 0 until busy falls.
- **Timeout (macro on, ACK_TIMEOUT=3).** Job issued, busy never rises.
  - Required: `timeout_o` pulses 3 cycles after entering WAIT_ACK, FSM IDLE, next FIFO job issued.
  - With the macro off: required FSM stays in WAIT_ACK for 100 cycles with `timeout_o`=0.
- **Reset mid-operation.** Assert `rst_i` in WAIT_DONE with 2 jobs queued.
  - Required: next cycle `fifo_count_o`=0, `select_o`=0, `rr`=0, no timeout pulse.

Source files
------------

// File: rtl/vec_dispatch_sched.sv
`default_nettype none
// ============================================================================
// Module      : vec_dispatch_sched
// Description : Round-robin dispatch scheduler that feeds the vector work
//               consumer. Requesters hand over 6-bit job codes through
//               valid/ready. A small FIFO buffers the accepted jobs. Each job
//               is issued as a one-cycle nonzero select pulse, and the
//               scheduler then follows the consumer's busy ack/complete
//               sequence before it issues the next job.
//               Optional feature macro: VEC_DISPATCH_TIMEOUT_EN. When it is
//               defined, a job is dropped if no acknowledge arrives in time.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_dispatch_sched #(
  parameter int NREQ        = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NREQ-1:0]               req_valid_i,
  input  logic [6*NREQ-1:0]             req_job_i,
  output logic [NREQ-1:0]               req_ready_o,
  input  logic                          busy_consumer_i,
  output logic [5:0]                    select_o,
  output logic [$clog2(NREQ)-1:0]       issue_src_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          timeout_o
);

  localparam int SRC_W = $clog2(NREQ);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Reject illegal parameter sets at elaboration time.
  generate
    if (NREQ < 2 || NREQ > 8 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_param_check
      $error("vec_dispatch_sched: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [SRC_W-1:0]   rr;
  logic [5:0]         fifo_job [FIFO_DEPTH];
  logic [SRC_W-1:0]   fifo_src [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic [NREQ-1:0]    eligible;
  logic               found;
  logic [SRC_W-1:0]   grant_idx;
  logic [5:0]         grant_job;
  logic [NREQ-1:0]    grant;
  logic               fifo_full;
  logic               push;
  logic               pop;

  // A requester competes only when it is valid and carries real work (job != 0).
  always_comb begin
    eligible = '0;
    for (int k = 0; k < NREQ; k++) begin
      eligible[k] = req_valid_i[k] && (req_job_i[6*k +: 6] != 6'd0);
    end
  end

  // Round-robin pick. First search indices at or above rr, then wrap to the
  // indices below rr.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && eligible[k] && (k >= int'(rr))) begin
        found     = 1'b1;
        grant_idx = SRC_W'(k);
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (!found && eligible[k] && (k < int'(rr))) begin
        found     = 1'b1;
        grant_idx = SRC_W'(k);
      end
    end
  end

  // Fullness uses the registered count only. A pop in the same cycle does not
  // make room for a push.
  assign fifo_full = (count == CNT_W'(FIFO_DEPTH));

  // One-hot grant and the granted job code. Nothing is granted while in reset.
  always_comb begin
    grant     = '0;
    grant_job = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (found && !fifo_full && !rst_i && (grant_idx == SRC_W'(k))) begin
        grant[k]  = 1'b1;
        grant_job = req_job_i[6*k +: 6];
      end
    end
  end

  assign req_ready_o = grant;
  assign push        = |grant;
  assign pop         = (state == IDLE) && (count != '0) && !busy_consumer_i;

  // After a grant to k, rr moves to the requester just past k.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr <= '0;
    end else if (push) begin
      rr <= (grant_idx == SRC_W'(NREQ - 1)) ? '0 : grant_idx + SRC_W'(1);
    end
  end

  // FIFO storage. Contents need no reset because the pointers and count
  // define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_job[wr_ptr] <= grant_job;
      fifo_src[wr_ptr] <= grant_idx;
    end
  end

  // FIFO pointers and occupancy. The pointers wrap naturally because the
  // depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign fifo_count_o = count;

`ifdef VEC_DISPATCH_TIMEOUT_EN
  localparam logic [7:0] ACK_LIMIT = 8'(ACK_TIMEOUT - 1);

  logic [7:0] ack_cnt;
  logic       timeout_hit;
  logic       timeout_q;

  // Count the cycles spent in WAIT_ACK with busy low. The counter clears as
  // the FSM enters WAIT_ACK.
  always_ff @(posedge clk_i) begin
    if (rst_i || state == ISSUE) begin
      ack_cnt <= '0;
    end else if (state == WAIT_ACK && !busy_consumer_i) begin
      ack_cnt <= ack_cnt + 8'd1;
    end
  end

  // Register the timeout so that the pulse lines up with the return to IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) timeout_q <= 1'b0;
    else       timeout_q <= timeout_hit;
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic. Busy seen in WAIT_ACK is the acknowledge, and busy
  // falling in WAIT_DONE is completion.
  always_comb begin
    state_nxt = state;
`ifdef VEC_DISPATCH_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      IDLE:      if (pop) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (busy_consumer_i) begin
          state_nxt = WAIT_DONE;
        end
`ifdef VEC_DISPATCH_TIMEOUT_EN
        else if (ack_cnt == ACK_LIMIT) begin
          state_nxt   = IDLE;
          timeout_hit = 1'b1;
        end
`endif
      end
      WAIT_DONE: if (!busy_consumer_i) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Issue register. It loads on the pop, so the job is visible exactly during
  // the ISSUE cycle and reads zero at every other time.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      select_o    <= '0;
      issue_src_o <= '0;
    end else if (pop) begin
      select_o    <= fifo_job[rd_ptr];
      issue_src_o <= fifo_src[rd_ptr];
    end else begin
      select_o    <= '0;
      issue_src_o <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vec_dispatch_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_vec_dispatch_sched
// Description : Scoreboard bench for vec_dispatch_sched. Directed stimulus
//               pushes the expected {src, job} issues into a queue, and a
//               monitor pops and compares them whenever select is nonzero.
//               The bench follows VEC_DISPATCH_TIMEOUT_EN in the same way as
//               the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_dispatch_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [23:0] req_job = '0;
  logic [3:0]  req_ready;
  logic        man_busy = 1'b0;
  logic        auto_busy = 1'b0;
  logic        saw_issue = 1'b0;
  logic        auto_ack = 1'b1;
  logic        busy;
  logic [5:0]  select;
  logic [1:0]  issue_src;
  logic [2:0]  fifo_count;
  logic        timeout;

  int          compared = 0;
  int          mismatched = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  mon_exp;

  assign busy = auto_ack ? auto_busy : man_busy;

  always #5 clk = ~clk;

  vec_dispatch_sched #(
    .NREQ(4), .FIFO_DEPTH(4), .ACK_TIMEOUT(3)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_job_i(req_job),
    .req_ready_o(req_ready), .busy_consumer_i(busy), .select_o(select),
    .issue_src_o(issue_src), .fifo_count_o(fifo_count), .timeout_o(timeout)
  );

  // Auto consumer: raise busy for one cycle, one cycle after each issue pulse.
  always @(negedge clk) begin
    auto_busy <= saw_issue;
    saw_issue <= (select != 6'd0);
  end

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic set_req(input int k, input int j);
    req_valid[k[1:0]] = 1'b1;
    req_job[6*k[1:0] +: 6] = j[5:0];
  endtask

  task automatic clr_req();
    req_valid = '0;
    req_job   = '0;
  endtask

  task automatic expect_issue(input int src, input int job);
    exp_q.push_back({src[1:0], job[5:0]});
  endtask

  // Leaves the bench at a negedge, with reset released and the DUT in its
  // reset state.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; clr_req(); auto_ack = 1'b1; man_busy = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    // Monitor: every nonzero select must match the head of the scoreboard.
    fork
      forever begin
        @(negedge clk);
        if (select != 6'd0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_issue", {issue_src, select}, 0);
          end else begin
            mon_exp = exp_q.pop_front();
            check("issue_order", {issue_src, select}, mon_exp);
          end
        end
      end
    join_none

    // ---------------- reset behaviour
    set_req(0, 7);
    @(negedge clk); #1;
    check("ready_in_reset", req_ready, 0);
    @(negedge clk);
    rst = 1'b0; clr_req();
    check("rst_select", select, 0);
    check("rst_src", issue_src, 0);
    check("rst_count", fifo_count, 0);
    check("rst_timeout", timeout, 0);

    // ---------------- single job, latency t+2, manual busy for 3 cycles
    auto_ack = 1'b0;
    @(negedge clk);
    set_req(1, 5); expect_issue(1, 5); #1;
    check("t1_ready", req_ready, 4'b0010);
    @(negedge clk); clr_req();
    check("t1_sel_t1", select, 0);
    check("t1_cnt_t1", fifo_count, 1);
    @(negedge clk);
    check("t1_sel_t2", select, 5);
    check("t1_src_t2", issue_src, 1);
    @(negedge clk);
    check("t1_sel_t3", select, 0);
    man_busy = 1'b1;
    repeat (3) @(negedge clk);
    man_busy = 1'b0;
    @(negedge clk);
    check("t1_cnt_end", fifo_count, 0);

    // ---------------- zero job never ready; IDLE accepts and issues next job
    set_req(0, 0); set_req(2, 9); expect_issue(2, 9); #1;
    check("zero_rr2_ready", req_ready, 4'b0100);
    @(negedge clk);
    req_valid[2] = 1'b0; #1;
    check("zero_only_ready", req_ready, 0);
    @(negedge clk);
    check("t2_sel", select, 9);
    @(negedge clk);
    man_busy = 1'b1;
    @(negedge clk);
    man_busy = 1'b0;
    bad = 0;
    repeat (4) begin
      #1; if (req_ready != 0) bad++;
      @(negedge clk);
    end
    check("zero_never_ready", bad, 0);
    clr_req();

    // ---------------- busy high in IDLE blocks the issue
    man_busy = 1'b1;
    set_req(3, 6'h2A); expect_issue(3, 6'h2A); #1;
    check("blk_ready", req_ready, 4'b1000);
    @(negedge clk); clr_req();
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (select != 0) bad++;
    end
    check("blk_no_issue", bad, 0);
    check("blk_count", fifo_count, 1);
    auto_ack = 1'b1;
    @(negedge clk);
    check("blk_sel_after_release", select, 6'h2A);
    wait_drain("blk_drain", 50);

    // ---------------- round robin: all four requesters valid
    do_reset();
    for (int k = 0; k < 4; k++) set_req(k, k + 1);
    expect_issue(0, 1); expect_issue(1, 2); expect_issue(2, 3);
    expect_issue(3, 4); expect_issue(0, 1);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("rr_grant", req_ready, 4'b0001 << (i % 4));
      @(negedge clk);
    end
    clr_req();
    wait_drain("rr_drain", 200);

    // ---------------- full FIFO under busy, then drain in order
    do_reset();
    auto_ack = 1'b0; man_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      clr_req(); set_req(i, 16 + i); expect_issue(i, 16 + i); #1;
      check("full_accept", req_ready, 4'b0001 << i);
      @(negedge clk);
    end
    clr_req(); set_req(0, 6'h14); expect_issue(0, 6'h14);
    repeat (3) begin
      #1;
      check("full_ready5", req_ready, 0);
      check("full_count", fifo_count, 4);
      @(negedge clk);
    end
    auto_ack = 1'b1; #1;
    check("full_pop_same_cycle", req_ready, 0);
    @(negedge clk); #1;
    check("full_count_after_pop", fifo_count, 3);
    check("full_ready5_late", req_ready, 4'b0001);
    @(negedge clk); clr_req();
    wait_drain("full_drain", 300);

    // ---------------- acknowledge timeout (or its absence)
    do_reset();
    auto_ack = 1'b0; man_busy = 1'b0;
    set_req(0, 6'h21); expect_issue(0, 6'h21); #1;
    check("to_ready0", req_ready, 4'b0001);
    @(negedge clk);
    clr_req(); set_req(1, 6'h22); expect_issue(1, 6'h22); #1;
    check("to_ready1", req_ready, 4'b0010);
    @(negedge clk); clr_req();
    check("to_sel_first", select, 6'h21);
`ifdef VEC_DISPATCH_TIMEOUT_EN
    for (int c = 3; c <= 7; c++) begin
      @(negedge clk);
      check("to_pulse", timeout, (c == 6) ? 1 : 0);
      check("to_next_issue", select, (c == 7) ? 6'h22 : 0);
    end
    wait_drain("to_drain", 50);
`else
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (timeout != 1'b0 || select != 6'd0) bad++;
    end
    check("noto_stuck", bad, 0);
    check("noto_count", fifo_count, 1);
    man_busy = 1'b1;
    @(negedge clk);
    man_busy = 1'b0;
    wait_drain("noto_drain", 50);
`endif

    // ---------------- reset in WAIT_DONE with two jobs queued
    do_reset();
    auto_ack = 1'b0; man_busy = 1'b0;
    set_req(0, 6'h31); expect_issue(0, 6'h31);
    @(negedge clk); clr_req(); set_req(1, 6'h32);
    @(negedge clk); clr_req(); set_req(2, 6'h33);
    @(negedge clk); clr_req();
    man_busy = 1'b1;
    @(negedge clk);
    check("mid_count_before", fifo_count, 2);
    @(negedge clk);
    rst = 1'b1;
    set_req(1, 6'h0B); set_req(3, 6'h0D); #1;
    check("mid_ready_in_reset", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    check("mid_count", fifo_count, 0);
    check("mid_select", select, 0);
    check("mid_timeout", timeout, 0);
    expect_issue(1, 6'h0B); #1;
    check("mid_rr_zero", req_ready, 4'b0010);
    @(negedge clk); clr_req();
    auto_ack = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (timeout != 1'b0) bad++;
    end
    check("mid_no_timeout", bad, 0);
    wait_drain("mid_drain", 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
